reel_sequencer: RTL and testbench

Spin sequencer for the one-arm-bandit datapath. Owns the credit counter and the three reel position registers, and runs one spin per accepted start request. Each spin follows a fixed sequence: spin all reels, stop them one at a time, evaluate the symbols, then pay out credits serially. It sits between the coin/start pulse sources and the display/scoring logic. It replaces ad-hoc reel stepping in the top level.

---
 rtl/reel_sequencer_if.sv | 31 +++
 rtl/reel_sequencer.sv | 178 +++++++++++++++++
 tb/tb_reel_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reel_sequencer_if.sv
// Bus between the coin/start pulse sources, the spin sequencer and the display/scoring side.
interface reel_sequencer_if #(
  parameter int unsigned SYM_W    = 3,
  parameter int unsigned CREDIT_W = 8
);

  logic                coin_p;
  logic                start_p;
  logic [2:0]          state;
  logic                busy;
  logic [SYM_W-1:0]    reel0;
  logic [SYM_W-1:0]    reel1;
  logic [SYM_W-1:0]    reel2;
  logic [CREDIT_W-1:0] credit;
  logic [4:0]          payout;
  logic                win_p;
  logic                reject_p;

  // Pulse source / observer side
  modport master (
    output coin_p, start_p,
    input  state, busy, reel0, reel1, reel2, credit, payout, win_p, reject_p
  );

  // Sequencer side
  modport slave (
    input  coin_p, start_p,
    output state, busy, reel0, reel1, reel2, credit, payout, win_p, reject_p
  );

endinterface

// File: rtl/reel_sequencer.sv
// Spin sequencer: owns credit and reel positions, runs spin -> staggered stop -> evaluate -> serial payout.
module reel_sequencer #(
  parameter int unsigned SYM_W       = 3,
  parameter int unsigned CREDIT_W    = 8,
  parameter int unsigned SPIN_CYCLES = 13,
  parameter int unsigned STAGGER     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  reel_sequencer_if.slave bus
);

  localparam int unsigned CNT_MAX = SPIN_CYCLES + 2 * STAGGER;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned PAY_W   = 5;
  localparam int unsigned SUM_W   = CREDIT_W + 2;

  localparam logic [CNT_W-1:0]    C_END_SPIN = CNT_W'(SPIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]    C_END_S1   = CNT_W'(SPIN_CYCLES + STAGGER - 1);
  localparam logic [CNT_W-1:0]    C_END_S2   = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0]    C_LIM0     = CNT_W'(SPIN_CYCLES);
  localparam logic [CNT_W-1:0]    C_LIM1     = CNT_W'(SPIN_CYCLES + STAGGER);
  localparam logic [CNT_W-1:0]    C_LIM2     = CNT_W'(CNT_MAX);
  localparam logic [SYM_W-1:0]    STEP0      = SYM_W'(1);
  localparam logic [SYM_W-1:0]    STEP1      = SYM_W'(3);
  localparam logic [SYM_W-1:0]    STEP2      = SYM_W'(5);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPIN  = 3'd1,
    S_STOP1 = 3'd2,
    S_STOP2 = 3'd3,
    S_EVAL  = 3'd4,
    S_PAY   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start_acc;
  logic                w_spinning;
  logic                w_pay_inc;
  logic [PAY_W-1:0]    w_eval;
  logic [SUM_W-1:0]    w_credit_sum;

  logic [CNT_W-1:0]    r_cnt;
  logic [SYM_W-1:0]    r_reel0;
  logic [SYM_W-1:0]    r_reel1;
  logic [SYM_W-1:0]    r_reel2;
  logic [CREDIT_W-1:0] r_credit;
  logic [PAY_W-1:0]    r_payout;
  logic [PAY_W-1:0]    r_pay_left;
  logic                r_busy;
  logic                r_win;
  logic                r_reject;

  // Symbol evaluation on the current (stopped) reels
  always_comb begin
    w_eval = '0;
    if ((r_reel0 == r_reel1) && (r_reel1 == r_reel2)) begin
      w_eval = (r_reel0 == '0) ? PAY_W'(16) : PAY_W'(8);
    end else if ((r_reel0 == r_reel1) || (r_reel1 == r_reel2) || (r_reel0 == r_reel2)) begin
      w_eval = PAY_W'(2);
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_spinning  = 1'b0;
    w_pay_inc   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start_p && ((r_credit != '0) || bus.coin_p)) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_SPIN;
        end
      end
      S_SPIN: begin
        w_spinning = 1'b1;
        if (r_cnt == C_END_SPIN) w_state_nxt = S_STOP1;
      end
      S_STOP1: begin
        w_spinning = 1'b1;
        if (r_cnt == C_END_S1) w_state_nxt = S_STOP2;
      end
      S_STOP2: begin
        w_spinning = 1'b1;
        if (r_cnt == C_END_S2) w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        w_state_nxt = (w_eval != '0) ? S_PAY : S_IDLE;
      end
      S_PAY: begin
        w_pay_inc = 1'b1;
        if (r_pay_left <= PAY_W'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Spin cycle counter, restarted by each accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_cnt <= '0;
    else if (w_start_acc) r_cnt <= '0;
    else if (w_spinning)  r_cnt <= r_cnt + CNT_W'(1);
  end

  // Reel stepping; each later reel keeps turning STAGGER cycles longer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reel0 <= '0;
      r_reel1 <= '0;
      r_reel2 <= '0;
    end else if (w_spinning) begin
      if (r_cnt < C_LIM0) r_reel0 <= r_reel0 + STEP0;
      if (r_cnt < C_LIM1) r_reel1 <= r_reel1 + STEP1;
      if (r_cnt < C_LIM2) r_reel2 <= r_reel2 + STEP2;
    end
  end

  // Saturating credit; start_acc never underflows since it needs credit or a coin
  assign w_credit_sum = SUM_W'(r_credit) + SUM_W'(bus.coin_p) + SUM_W'(w_pay_inc)
                      - SUM_W'(w_start_acc);

  // Credit balance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_credit <= '0;
    else if (w_credit_sum > SUM_W'(CREDIT_MAX))  r_credit <= CREDIT_MAX;
    else                                         r_credit <= w_credit_sum[CREDIT_W-1:0];
  end

  // Payout value (held until next start) and remaining units to pay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_payout   <= '0;
      r_pay_left <= '0;
    end else if (w_start_acc) begin
      r_payout   <= '0;
    end else if (r_state == S_EVAL) begin
      r_payout   <= w_eval;
      r_pay_left <= w_eval;
    end else if (w_pay_inc) begin
      r_pay_left <= r_pay_left - PAY_W'(1);
    end
  end

  // Registered status flags and pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_win    <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_busy   <= (w_state_nxt != S_IDLE);
      r_win    <= (r_state == S_EVAL) && (w_eval != '0);
      r_reject <= (r_state == S_IDLE) && bus.start_p && (r_credit == '0) && !bus.coin_p;
    end
  end

  assign bus.state    = 3'(r_state);
  assign bus.busy     = r_busy;
  assign bus.reel0    = r_reel0;
  assign bus.reel1    = r_reel1;
  assign bus.reel2    = r_reel2;
  assign bus.credit   = r_credit;
  assign bus.payout   = r_payout;
  assign bus.win_p    = r_win;
  assign bus.reject_p = r_reject;

endmodule

// File: tb/tb_reel_sequencer.sv
// Directed bench for reel_sequencer across four parameter sets.
module tb_reel_sequencer;

  logic       clk;
  logic [3:0] rstn_v;
  logic       coin_v [4];
  logic       start_v[4];

  logic [2:0] o_state [4];
  logic       o_busy  [4];
  logic [2:0] o_reel0 [4];
  logic [2:0] o_reel1 [4];
  logic [2:0] o_reel2 [4];
  logic [7:0] o_credit[4];
  logic [4:0] o_payout[4];
  logic       o_win   [4];
  logic       o_rej   [4];

  logic [2:0] st_log[64];

  int n_tests = 0;
  int n_fail  = 0;

  reel_sequencer_if #(.SYM_W(3), .CREDIT_W(8)) if0 ();
  reel_sequencer_if #(.SYM_W(3), .CREDIT_W(8)) if1 ();
  reel_sequencer_if #(.SYM_W(3), .CREDIT_W(8)) if2 ();
  reel_sequencer_if #(.SYM_W(3), .CREDIT_W(4)) if3 ();

  reel_sequencer #(.SYM_W(3), .CREDIT_W(8), .SPIN_CYCLES(13), .STAGGER(5))
    u_dut0 (.clk(clk), .rst_n(rstn_v[0]), .bus(if0));
  reel_sequencer #(.SYM_W(3), .CREDIT_W(8), .SPIN_CYCLES(8), .STAGGER(8))
    u_dut1 (.clk(clk), .rst_n(rstn_v[1]), .bus(if1));
  reel_sequencer #(.SYM_W(3), .CREDIT_W(8), .SPIN_CYCLES(4), .STAGGER(4))
    u_dut2 (.clk(clk), .rst_n(rstn_v[2]), .bus(if2));
  reel_sequencer #(.SYM_W(3), .CREDIT_W(4), .SPIN_CYCLES(8), .STAGGER(8))
    u_dut3 (.clk(clk), .rst_n(rstn_v[3]), .bus(if3));

  assign if0.coin_p = coin_v[0];  assign if0.start_p = start_v[0];
  assign if1.coin_p = coin_v[1];  assign if1.start_p = start_v[1];
  assign if2.coin_p = coin_v[2];  assign if2.start_p = start_v[2];
  assign if3.coin_p = coin_v[3];  assign if3.start_p = start_v[3];

  assign o_state[0] = if0.state;  assign o_busy[0] = if0.busy;
  assign o_reel0[0] = if0.reel0;  assign o_reel1[0] = if0.reel1;  assign o_reel2[0] = if0.reel2;
  assign o_credit[0] = if0.credit; assign o_payout[0] = if0.payout;
  assign o_win[0] = if0.win_p;    assign o_rej[0] = if0.reject_p;

  assign o_state[1] = if1.state;  assign o_busy[1] = if1.busy;
  assign o_reel0[1] = if1.reel0;  assign o_reel1[1] = if1.reel1;  assign o_reel2[1] = if1.reel2;
  assign o_credit[1] = if1.credit; assign o_payout[1] = if1.payout;
  assign o_win[1] = if1.win_p;    assign o_rej[1] = if1.reject_p;

  assign o_state[2] = if2.state;  assign o_busy[2] = if2.busy;
  assign o_reel0[2] = if2.reel0;  assign o_reel1[2] = if2.reel1;  assign o_reel2[2] = if2.reel2;
  assign o_credit[2] = if2.credit; assign o_payout[2] = if2.payout;
  assign o_win[2] = if2.win_p;    assign o_rej[2] = if2.reject_p;

  assign o_state[3] = if3.state;  assign o_busy[3] = if3.busy;
  assign o_reel0[3] = if3.reel0;  assign o_reel1[3] = if3.reel1;  assign o_reel2[3] = if3.reel2;
  assign o_credit[3] = 8'(if3.credit); assign o_payout[3] = if3.payout;
  assign o_win[3] = if3.win_p;    assign o_rej[3] = if3.reject_p;

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_coin(input int k);
    coin_v[k] = 1'b1;
    tick();
    coin_v[k] = 1'b0;
  endtask

  task automatic pulse_start(input int k, input bit with_coin);
    start_v[k] = 1'b1;
    coin_v[k]  = with_coin;
    tick();
    start_v[k] = 1'b0;
    coin_v[k]  = 1'b0;
  endtask

  // Follow a spin from just after its start edge until busy drops (bounded)
  task automatic run_spin(input int k, input bit coin_in_pay,
                          output int busy_n, output int pay_n, output int win_n,
                          output logic [7:0] cred_first_pay);
    bit coin_done = 1'b0;
    bit got       = 1'b0;
    busy_n = 0; pay_n = 0; win_n = 0; cred_first_pay = '0;
    for (int i = 0; i < 200 && o_busy[k]; i++) begin
      if (i < 64) st_log[i] = o_state[k];
      busy_n++;
      if (o_state[k] == 3'd5) pay_n++;
      if (o_win[k]) win_n++;
      if (coin_in_pay && !coin_done && o_state[k] == 3'd5) begin
        coin_v[k] = 1'b1;
        coin_done = 1'b1;
      end
      tick();
      coin_v[k] = 1'b0;
      if (coin_done && !got) begin
        cred_first_pay = o_credit[k];
        got = 1'b1;
      end
    end
    chk("spin_returns_idle", 32'(o_busy[k]), 0);
  endtask

  int         b_n, p_n, w_n;
  logic [7:0] c1;

  initial begin
    rstn_v = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      coin_v[k]  = 1'b0;
      start_v[k] = 1'b0;
    end
    tick(); tick();
    chk("rst_held_state", 32'(o_state[0]), 0);
    chk("rst_held_credit", 32'(o_credit[0]), 0);
    rstn_v = 4'b1111;
    tick();

    // Reset values
    chk("rst_state",  32'(o_state[0]), 0);
    chk("rst_busy",   32'(o_busy[0]), 0);
    chk("rst_reel0",  32'(o_reel0[0]), 0);
    chk("rst_reel1",  32'(o_reel1[0]), 0);
    chk("rst_reel2",  32'(o_reel2[0]), 0);
    chk("rst_credit", 32'(o_credit[0]), 0);
    chk("rst_payout", 32'(o_payout[0]), 0);
    chk("rst_win",    32'(o_win[0]), 0);
    chk("rst_reject", 32'(o_rej[0]), 0);

    // Default parameters: one coin, one losing spin
    pulse_coin(0);
    chk("a_credit_coin", 32'(o_credit[0]), 1);
    pulse_start(0, 1'b0);
    chk("a_credit_start", 32'(o_credit[0]), 0);
    chk("a_state_spin", 32'(o_state[0]), 1);
    run_spin(0, 1'b0, b_n, p_n, w_n, c1);
    chk("a_busy_cycles", 32'(b_n), 24);
    chk("a_st12_spin",  32'(st_log[12]), 1);
    chk("a_st13_stop1", 32'(st_log[13]), 2);
    chk("a_st17_stop1", 32'(st_log[17]), 2);
    chk("a_st18_stop2", 32'(st_log[18]), 3);
    chk("a_st23_eval",  32'(st_log[23]), 4);
    chk("a_reel0", 32'(o_reel0[0]), 5);
    chk("a_reel1", 32'(o_reel1[0]), 6);
    chk("a_reel2", 32'(o_reel2[0]), 3);
    chk("a_payout", 32'(o_payout[0]), 0);
    chk("a_win_cnt", 32'(w_n), 0);
    chk("a_state_idle", 32'(o_state[0]), 0);

    // Start without credit is rejected once
    pulse_start(0, 1'b0);
    chk("b_reject", 32'(o_rej[0]), 1);
    chk("b_state_idle", 32'(o_state[0]), 0);
    chk("b_credit", 32'(o_credit[0]), 0);
    tick();
    chk("b_reject_once", 32'(o_rej[0]), 0);

    // Start during SPIN is ignored without reject
    pulse_coin(0);
    pulse_start(0, 1'b0);
    tick(); tick(); tick();
    pulse_start(0, 1'b0);
    chk("b_no_reject_spin", 32'(o_rej[0]), 0);
    chk("b_still_spin", 32'(o_state[0]), 1);
    chk("b_credit_spin", 32'(o_credit[0]), 0);
    run_spin(0, 1'b0, b_n, p_n, w_n, c1);
    chk("b_busy_rest", 32'(b_n), 20);
    chk("b_reel0", 32'(o_reel0[0]), 2);
    chk("b_reel1", 32'(o_reel1[0]), 4);
    chk("b_reel2", 32'(o_reel2[0]), 6);

    // Reset in the middle of STOP1
    pulse_coin(0);
    pulse_coin(0);
    pulse_start(0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("f_in_stop1", 32'(o_state[0]), 2);
    chk("f_credit_pre", 32'(o_credit[0]), 1);
    rstn_v[0] = 1'b0;
    #1;
    chk("f_rst_state",  32'(o_state[0]), 0);
    chk("f_rst_busy",   32'(o_busy[0]), 0);
    chk("f_rst_reel0",  32'(o_reel0[0]), 0);
    chk("f_rst_reel1",  32'(o_reel1[0]), 0);
    chk("f_rst_reel2",  32'(o_reel2[0]), 0);
    chk("f_rst_credit", 32'(o_credit[0]), 0);
    chk("f_rst_payout", 32'(o_payout[0]), 0);
    tick();
    rstn_v[0] = 1'b1;
    tick();
    pulse_coin(0);
    pulse_start(0, 1'b0);
    run_spin(0, 1'b0, b_n, p_n, w_n, c1);
    chk("f_busy_cycles", 32'(b_n), 24);
    chk("f_reel0", 32'(o_reel0[0]), 5);
    chk("f_reel1", 32'(o_reel1[0]), 6);
    chk("f_reel2", 32'(o_reel2[0]), 3);

    // Jackpot: SPIN_CYCLES=8, STAGGER=8
    pulse_coin(1);
    pulse_start(1, 1'b0);
    chk("c_credit_start", 32'(o_credit[1]), 0);
    run_spin(1, 1'b0, b_n, p_n, w_n, c1);
    chk("c_busy_cycles", 32'(b_n), 41);
    chk("c_pay_cycles", 32'(p_n), 16);
    chk("c_win_cnt", 32'(w_n), 1);
    chk("c_reel0", 32'(o_reel0[1]), 0);
    chk("c_reel1", 32'(o_reel1[1]), 0);
    chk("c_reel2", 32'(o_reel2[1]), 0);
    chk("c_payout", 32'(o_payout[1]), 16);
    chk("c_credit_end", 32'(o_credit[1]), 16);

    // Pair win with a coin in the first PAY cycle: SPIN_CYCLES=4, STAGGER=4
    pulse_coin(2);
    pulse_start(2, 1'b0);
    run_spin(2, 1'b1, b_n, p_n, w_n, c1);
    chk("d_busy_cycles", 32'(b_n), 15);
    chk("d_pay_cycles", 32'(p_n), 2);
    chk("d_win_cnt", 32'(w_n), 1);
    chk("d_credit_coin_pay", 32'(c1), 2);
    chk("d_credit_end", 32'(o_credit[2]), 3);
    chk("d_payout", 32'(o_payout[2]), 2);
    chk("d_reel0", 32'(o_reel0[2]), 4);
    chk("d_reel1", 32'(o_reel1[2]), 0);
    chk("d_reel2", 32'(o_reel2[2]), 4);

    // CREDIT_W=4: coin+start together at zero credit, then saturating jackpots
    pulse_start(3, 1'b1);
    chk("e_accept_state", 32'(o_state[3]), 1);
    chk("e_accept_credit", 32'(o_credit[3]), 0);
    chk("e_accept_no_rej", 32'(o_rej[3]), 0);
    run_spin(3, 1'b0, b_n, p_n, w_n, c1);
    chk("e_pay_cycles1", 32'(p_n), 16);
    chk("e_credit_sat1", 32'(o_credit[3]), 15);
    pulse_start(3, 1'b0);
    chk("e_credit_start2", 32'(o_credit[3]), 14);
    run_spin(3, 1'b0, b_n, p_n, w_n, c1);
    chk("e_pay_cycles2", 32'(p_n), 16);
    chk("e_credit_sat2", 32'(o_credit[3]), 15);
    chk("e_payout", 32'(o_payout[3]), 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
